// File: rtl/button_debounce.sv
// button_debounce: conditions a raw, bouncy, asynchronous push-button pin into
// a clean debounced level with press, release and long-press strobes and a
// wrapping press counter. Single clock domain, synchronous active-high reset.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 480_000,
   parameter int unsigned LONG_CYCLES     = 24_000_000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_raw,
   output logic       btn_state,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic [7:0] press_count
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

   localparam logic [DW-1:0] DEB_ZERO  = DW'(0);
   localparam logic [DW-1:0] DEB_ONE   = DW'(1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

   // Pin level when the button is not pressed.
   localparam logic PIN_IDLE = ACTIVE_LOW;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ARM_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      ARM_RELEASE = 2'd3
   } state_t;

   state_t        state;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   logic          sync1;
   logic          sync2;
   logic          sample;

   // Normalised polarity: sample = 1 means the button is pressed.
   assign sample = sync2 ^ PIN_IDLE;

   // Two-flop synchronizer; reset loads the inactive pin level so no edge is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= PIN_IDLE;
         sync2 <= PIN_IDLE;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Debounce FSM with hold timer; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         deb_cnt       <= DEB_ZERO;
         hold_cnt      <= HOLD_ZERO;
         btn_state     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         press_count   <= 8'd0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         case (state)
            IDLE: begin
               if (sample) begin
                  state   <= ARM_PRESS;
                  deb_cnt <= DEB_ONE;
               end else begin
                  deb_cnt <= DEB_ZERO;
               end
            end
            ARM_PRESS: begin
               if (!sample) begin
                  state   <= IDLE;
                  deb_cnt <= DEB_ZERO;
               end else if (deb_cnt == DEB_LAST) begin
                  state       <= PRESSED;
                  deb_cnt     <= DEB_ZERO;
                  btn_state   <= 1'b1;
                  press_pulse <= 1'b1;
                  press_count <= press_count + 8'd1;
                  hold_cnt    <= HOLD_ZERO;
               end else begin
                  deb_cnt <= deb_cnt + DEB_ONE;
               end
            end
            PRESSED, ARM_RELEASE: begin
               // The hold timer runs for the whole press, including release bounce,
               // and saturates so long_pulse can fire only once.
               if (hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + HOLD_ONE;
               end else begin
                  hold_cnt <= hold_cnt;
               end
               if (hold_cnt == HOLD_LAST) begin
                  long_pulse <= 1'b1;
               end else begin
                  long_pulse <= 1'b0;
               end
               if (state == PRESSED) begin
                  if (!sample) begin
                     state   <= ARM_RELEASE;
                     deb_cnt <= DEB_ONE;
                  end else begin
                     deb_cnt <= DEB_ZERO;
                  end
               end else begin
                  if (sample) begin
                     state   <= PRESSED;
                     deb_cnt <= DEB_ZERO;
                  end else if (deb_cnt == DEB_LAST) begin
                     state         <= IDLE;
                     deb_cnt       <= DEB_ZERO;
                     btn_state     <= 1'b0;
                     release_pulse <= 1'b1;
                  end else begin
                     deb_cnt <= deb_cnt + DEB_ONE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               deb_cnt <= DEB_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: drives an active-low and an active-high instance with
// mirrored pin stimulus and compares both every cycle against a sample-history
// reference model of the debounce rules.
module tb_button_debounce;

   localparam int D = 4;
   localparam int L = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_lo;
   logic       btn_hi;

   logic       lo_state, lo_press, lo_rel, lo_long;
   logic [7:0] lo_count;
   logic       hi_state, hi_press, hi_rel, hi_long;
   logic [7:0] hi_count;

   int vectors = 0;
   int errs    = 0;

   // Reference model state
   bit         pipe0, pipe1;
   bit         hist[$];
   bit         m_level;
   int         m_held;
   logic [7:0] m_count;
   bit         m_press, m_rel, m_long;

   always #5 clk = ~clk;

   button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) u_lo (
      .clk(clk), .reset(reset), .btn_raw(btn_lo),
      .btn_state(lo_state), .press_pulse(lo_press), .release_pulse(lo_rel),
      .long_pulse(lo_long), .press_count(lo_count)
   );

   button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) u_hi (
      .clk(clk), .reset(reset), .btn_raw(btn_hi),
      .btn_state(hi_state), .press_pulse(hi_press), .release_pulse(hi_rel),
      .long_pulse(hi_long), .press_count(hi_count)
   );

   // One clock edge of the model: a level flips once the last D synchronized
   // samples all disagree with it; a long press is L edges after acceptance.
   task automatic model_edge(input bit rst, input bit pressed);
      int  ones;
      bit  sample;
      if (rst) begin
         pipe0 = 1'b0;
         pipe1 = 1'b0;
         hist.delete();
         for (int i = 0; i < D; i++) hist.push_back(1'b0);
         m_level = 1'b0;
         m_held  = 0;
         m_count = 8'd0;
         m_press = 1'b0;
         m_rel   = 1'b0;
         m_long  = 1'b0;
      end else begin
         sample = pipe1;
         pipe1  = pipe0;
         pipe0  = pressed;
         void'(hist.pop_front());
         hist.push_back(sample);
         m_press = 1'b0;
         m_rel   = 1'b0;
         m_long  = 1'b0;
         if (m_level && m_held < L) begin
            m_held++;
            if (m_held == L) m_long = 1'b1;
         end
         ones = 0;
         foreach (hist[i]) if (hist[i]) ones++;
         if (!m_level && ones == D) begin
            m_level = 1'b1;
            m_press = 1'b1;
            m_count = m_count + 8'd1;
            m_held  = 0;
         end else if (m_level && ones == 0) begin
            m_level = 1'b0;
            m_rel   = 1'b1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus (pressed = logical button state) and check both DUTs.
   task automatic step(input bit rst, input bit pressed);
      reset  = rst;
      btn_lo = ~pressed;
      btn_hi = pressed;
      @(posedge clk);
      model_edge(rst, pressed);
      #1;
      vectors++;
      chk("lo.btn_state",     {7'd0, lo_state}, {7'd0, m_level});
      chk("lo.press_pulse",   {7'd0, lo_press}, {7'd0, m_press});
      chk("lo.release_pulse", {7'd0, lo_rel},   {7'd0, m_rel});
      chk("lo.long_pulse",    {7'd0, lo_long},  {7'd0, m_long});
      chk("lo.press_count",   lo_count,         m_count);
      chk("hi.btn_state",     {7'd0, hi_state}, {7'd0, m_level});
      chk("hi.press_pulse",   {7'd0, hi_press}, {7'd0, m_press});
      chk("hi.release_pulse", {7'd0, hi_rel},   {7'd0, m_rel});
      chk("hi.long_pulse",    {7'd0, hi_long},  {7'd0, m_long});
      chk("hi.press_count",   hi_count,         m_count);
   endtask

   task automatic hold(input bit pressed, input int n);
      for (int i = 0; i < n; i++) step(1'b0, pressed);
   endtask

   initial begin
      int         len;
      bit         lvl;
      int         press_seen;
      int         press_at;
      int         long_at;

      // Reset held 3 cycles while the button is pressed, then a fresh press.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      chk("reset.count", lo_count, 8'd0);
      chk("reset.state", {7'd0, lo_state}, 8'd0);
      press_seen = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b1);
         if (lo_press) press_seen = i;
      end
      chk("reset.press_edge", 8'(press_seen), 8'd6);
      chk("reset.press_count", lo_count, 8'd1);
      hold(1'b0, 10);

      // Clean press: btn_state rises 6 edges after the pin edge.
      press_seen = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b1);
         if (lo_press && press_seen == 0) press_seen = i;
      end
      chk("clean.press_edge", 8'(press_seen), 8'd6);
      hold(1'b0, 10);

      // Bounce: toggle every 2 cycles for 12 cycles, then released.
      for (int i = 0; i < 12; i++) step(1'b0, ((i / 2) % 2) == 0);
      hold(1'b0, 10);
      chk("bounce.count", lo_count, 8'd2);

      // Long press: long_pulse 20 cycles after press_pulse.
      press_at = 0;
      long_at  = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b0, 1'b1);
         if (lo_press) press_at = i;
         if (lo_long)  long_at  = i;
      end
      chk("long.distance", 8'(long_at - press_at), 8'd20);
      hold(1'b0, 10);

      // Release bounce while pressed.
      hold(1'b1, 8);
      hold(1'b0, 3);
      hold(1'b1, 10);
      chk("relbounce.state", {7'd0, lo_state}, 8'd1);
      hold(1'b0, 10);

      // Random segments, including glitches, long holds and mid-run resets.
      for (int s = 0; s < 200; s++) begin
         if ($urandom_range(19, 0) == 0) begin
            len = int'($urandom_range(3, 1));
            for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(1, 0)));
         end
         lvl = 1'($urandom_range(1, 0));
         len = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 15))
                                          : int'($urandom_range(8, 1));
         hold(lvl, len);
      end

      // Wrap: 256 clean presses from reset bring press_count back to 0.
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      for (int p = 0; p < 256; p++) begin
         hold(1'b1, 7);
         hold(1'b0, 7);
      end
      chk("wrap.lo_count", lo_count, 8'd0);
      chk("wrap.hi_count", hi_count, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
